// File: rtl/mul_issue_ctrl_pkg.sv
// Shared multiply-op encoding and result-half selection for the MUL issue path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   MUL_OP_W    width of the multiply opcode field
//   mul_op_e    opcode encoding, also used by the instruction decoder
//   sel_half()  picks the 32-bit half of a 64-bit product that an opcode returns
package mul_issue_ctrl_pkg;

  localparam int MUL_OP_W = 2;

  typedef enum logic [MUL_OP_W-1:0] {
    OP_MUL_W   = 2'b00,  // low 32 bits of the product
    OP_MULH_W  = 2'b01,  // high 32 bits, signed x signed
    OP_MULH_WU = 2'b10,  // high 32 bits, unsigned x unsigned
    OP_RSVD    = 2'b11   // reserved: retires normally with a zero result
  } mul_op_e;

  // Returns the half of the product an opcode delivers. The low half of a
  // product is the same for signed and unsigned operands, so MUL_W does not
  // care which multiplier mode produced it.
  function automatic logic [31:0] sel_half(input logic [MUL_OP_W-1:0] op,
                                           input logic [63:0]         prod);
    logic [31:0] res;
    res = 32'h0;
    case (op)
      OP_MUL_W:              res = prod[31:0];
      OP_MULH_W, OP_MULH_WU: res = prod[63:32];
      default:               res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_multiplier.sv
// Combinational 32x32 -> 64 multiplier, radix-4 Booth recoded, signed or unsigned.
// Latency: 0 cycles (pure combinational); the clock/reset only qualify an X-check.
// Backpressure: none; output follows the inputs.
//
// Ports:
//   mul_clk     clock of the surrounding pipeline (qualifies the X-check only)
//   reset       async active-high reset of the surrounding pipeline
//   i_x         multiplicand
//   i_y         multiplier
//   i_signed    1: operands are two's complement, 0: operands are unsigned
//   o_prod      full 64-bit product
module multiplier (
  input  logic        mul_clk,
  input  logic        reset,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic        i_signed,
  output logic [63:0] o_prod
);

  // Operands widened so that an unsigned 32-bit value becomes a positive
  // signed value; the Booth recode then treats every case as signed.
  logic [63:0] w_x64;
  logic [33:0] w_y34;
  logic [34:0] w_yb;    // multiplier with the implicit y[-1] = 0 appended
  logic [63:0] w_x2;
  logic [2:0]  w_grp;
  logic [63:0] w_pp;
  logic [63:0] w_acc;

  assign w_x64 = i_signed ? {{32{i_x[31]}}, i_x} : {32'h0, i_x};
  assign w_y34 = i_signed ? {{2{i_y[31]}}, i_y}  : {2'b00, i_y};
  assign w_yb  = {w_y34, 1'b0};
  assign w_x2  = w_x64 << 1;

  // 17 Booth digits cover all 34 bits of the widened multiplier. Each digit
  // is in {-2,-1,0,+1,+2}; partial products are summed modulo 2^64, which is
  // exact for the two's-complement 64-bit result.
  always_comb begin
    w_acc = 64'h0;
    w_grp = 3'b000;
    w_pp  = 64'h0;
    for (int i = 0; i < 17; i++) begin
      w_grp = w_yb[2*i +: 3];
      case (w_grp)
        3'b001, 3'b010: w_pp = w_x64;
        3'b011:         w_pp = w_x2;
        3'b100:         w_pp = 64'h0 - w_x2;
        3'b101, 3'b110: w_pp = 64'h0 - w_x64;
        default:        w_pp = 64'h0;
      endcase
      w_acc = w_acc + (w_pp << (2*i));
    end
  end

  assign o_prod = w_acc;

  // Catch undriven operands reaching the product while the pipeline runs.
  a_prod_known: assert property (@(posedge mul_clk) disable iff (reset)
                                 !$isunknown(o_prod));

endmodule

// File: rtl/mul_issue_ctrl.sv
// Two-stage MUL/MULH issue pipeline around the combinational multiplier, EXE->MEM path.
// Latency: request accepted at one edge is presented on out_* after the following edge; 1 op/cycle.
// Backpressure: valid/ready; a stalled S2 blocks S1, a full S1 drops in_ready; flush kills both stages.
//
// Ports:
//   mul_clk, reset        clock (rising edge) and async active-high reset
//   flush                 discard every in-flight op at the next edge; blocks acceptance
//   in_valid/in_ready     request handshake
//   in_op, in_x, in_y     opcode (mul_op_e) and operands
//   in_tag                destination tag carried with the op
//   out_valid/out_ready   result handshake
//   out_result, out_tag   selected product half and its tag
//   busy                  some stage holds a valid op
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                mul_clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [31:0]         in_x,
  input  logic [31:0]         in_y,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  // S1: operands waiting in front of the multiplier
  logic                r_v1;
  logic [MUL_OP_W-1:0] r_op1;
  logic [31:0]         r_x1;
  logic [31:0]         r_y1;
  logic [TAG_W-1:0]    r_tag1;

  // S2: registered product waiting for the consumer
  logic                r_v2;
  logic [MUL_OP_W-1:0] r_op2;
  logic [63:0]         r_prod2;
  logic [TAG_W-1:0]    r_tag2;

  logic                w_adv1;
  logic                w_adv2;
  logic                w_accept;
  logic                w_mul_signed;
  logic [63:0]         w_prod;

  // A stage may load when it is empty or its content moves on this edge.
  assign w_adv2   = ~r_v2 | out_ready;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign in_ready = ~flush & w_adv1;
  assign w_accept = in_valid & in_ready;

  // Only MULH_WU needs unsigned operands; MUL_W's low half is mode-agnostic.
  assign w_mul_signed = (r_op1 != OP_MULH_WU);

  multiplier u_multiplier (
    .mul_clk  (mul_clk),
    .reset    (reset),
    .i_x      (r_x1),
    .i_y      (r_y1),
    .i_signed (w_mul_signed),
    .o_prod   (w_prod)
  );

  // Valid bits: flush wins over any advance. A result taken in the flush
  // cycle has already handshaked, so clearing v2 loses nothing.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv1) r_v1 <= w_accept;
    end
  end

  // S1 payload loads only on an accepted request so that the multiplier
  // inputs stay quiet between ops.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      r_op1  <= '0;
      r_x1   <= 32'h0;
      r_y1   <= 32'h0;
      r_tag1 <= '0;
    end else if (w_accept) begin
      r_op1  <= in_op;
      r_x1   <= in_x;
      r_y1   <= in_y;
      r_tag1 <= in_tag;
    end
  end

  // S2 payload loads only when a valid op moves down; otherwise it keeps the
  // last result, which also holds out_result/out_tag steady during a stall.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      r_op2   <= '0;
      r_prod2 <= 64'h0;
      r_tag2  <= '0;
    end else if (w_adv2 && r_v1) begin
      r_op2   <= r_op1;
      r_prod2 <= w_prod;
      r_tag2  <= r_tag1;
    end
  end

  assign out_valid  = r_v2;
  assign out_result = sel_half(r_op2, r_prod2);
  assign out_tag    = r_tag2;
  assign busy       = r_v1 | r_v2;

endmodule
